// File: rtl/debounce_scheduler_if.sv
// ---------------------------------------------------------------------------
// debounce_scheduler_if
//
// Purpose : groups the button inputs and the scheduler status outputs of
//           debounce_scheduler into one bundle.
//
// Signals : btn_n        raw active-low buttons (board side -> scheduler)
//           press_pulse  one-cycle pulse per debounced press
//           busy         shared timer is running a window or finishing one
//           grant_idx    index of the button currently owning the timer
//           pend_mask    buttons released and waiting for the timer
//
// Modports: master - the side driving the buttons and reading the results
//           slave  - the scheduler itself
// ---------------------------------------------------------------------------
interface debounce_scheduler_if #(
    parameter int NUM_BTNS = 4
);
    logic [NUM_BTNS-1:0] btn_n;
    logic [NUM_BTNS-1:0] press_pulse;
    logic                busy;
    logic [2:0]          grant_idx;
    logic [NUM_BTNS-1:0] pend_mask;

    modport master (
        output btn_n,
        input  press_pulse,
        input  busy,
        input  grant_idx,
        input  pend_mask
    );

    modport slave (
        input  btn_n,
        output press_pulse,
        output busy,
        output grant_idx,
        output pend_mask
    );
endinterface

// File: rtl/debounce_scheduler.sv
// ---------------------------------------------------------------------------
// debounce_scheduler
//
// Purpose : debounces up to eight active-low push buttons with a single
//           shared window timer. Each button is synchronised and tracked
//           through press and release; released buttons wait in PEND and a
//           round-robin arbiter hands the timer to one of them at a time.
//           When a window expires the owning button gets a one-cycle
//           press pulse and returns to HIGH.
//
// Ports   : clk  - clock
//           rst  - asynchronous, active-high reset
//           bus  - debounce_scheduler_if.slave
//                    btn_n (in), press_pulse / busy / grant_idx /
//                    pend_mask (out)
//
// Parameters:
//           NUM_BTNS        - number of buttons, 1..8
//           DEBOUNCE_CYCLES - window length in clk cycles, 2..2^22
//
// Build option:
//           DEBOUNCE_RESTART_EN - when defined, a low sample on the granted
//           button during the window restarts the window, so the pulse only
//           follows DEBOUNCE_CYCLES consecutive released samples. When not
//           defined the window is a fixed length from the first release.
// ---------------------------------------------------------------------------
module debounce_scheduler #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 2400000
) (
    input  logic                clk,
    input  logic                rst,
    debounce_scheduler_if.slave bus
);

    localparam logic [21:0] LAST_COUNT = 22'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        B_HIGH,
        B_LOW,
        B_PEND
    } btn_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_DONE
    } tmr_state_e;

    // Synchroniser; sync2_q is the clean level every FSM works from.
    logic [NUM_BTNS-1:0] sync1_q;
    logic [NUM_BTNS-1:0] sync2_q;

    btn_state_e          btn_state_q [NUM_BTNS];
    logic [NUM_BTNS-1:0] pend;

    tmr_state_e          tmr_state_q;
    logic [21:0]         count_q;
    logic [2:0]          grant_idx_q;
    logic [2:0]          rr_ptr_q;
    logic                busy_q;
    logic [NUM_BTNS-1:0] press_pulse_q;

    // Arbiter and decode results
    logic                hi_valid;
    logic [2:0]          hi_idx;
    logic                lo_valid;
    logic [2:0]          lo_idx;
    logic                grant_valid_d;
    logic [2:0]          grant_idx_d;
    logic [NUM_BTNS-1:0] pulse_d;
    logic [2:0]          rr_ptr_d;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser. Resetting to 1 (released) means the button
    // FSMs see no spurious press while the flops refill after reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, independent of block ordering.
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= bus.btn_n;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Per-button FSM: HIGH -> LOW on press, LOW -> PEND on release, and
    // PEND -> HIGH once the timer finishes this button's window. While in
    // PEND the input is ignored here; only the timer looks at it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the state array is a handful of flops, not a RAM, so it is
        // reset like any other control register.
        if (rst) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                btn_state_q[i] <= B_HIGH;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                case (btn_state_q[i])
                    B_HIGH: if (!sync2_q[i]) btn_state_q[i] <= B_LOW;
                    B_LOW:  if (sync2_q[i])  btn_state_q[i] <= B_PEND;
                    B_PEND: begin
                        if (tmr_state_q == T_DONE && grant_idx_q == 3'(i)) begin
                            btn_state_q[i] <= B_HIGH;
                        end
                    end
                    default: btn_state_q[i] <= B_HIGH;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first PEND index at or after rr_ptr, wrapping.
    // Scanning downwards leaves the lowest qualifying index in each half;
    // the half at/above rr_ptr takes priority over the wrapped half.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        pend     = '0;
        pulse_d  = '0;
        hi_valid = 1'b0;
        hi_idx   = '0;
        lo_valid = 1'b0;
        lo_idx   = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            pend[i]    = (btn_state_q[i] == B_PEND);
            pulse_d[i] = (grant_idx_q == 3'(i));
            if (pend[i]) begin
                if (3'(i) >= rr_ptr_q) begin
                    hi_valid = 1'b1;
                    hi_idx   = 3'(i);
                end else begin
                    lo_valid = 1'b1;
                    lo_idx   = 3'(i);
                end
            end
        end
        grant_valid_d = hi_valid | lo_valid;
        grant_idx_d   = hi_valid ? hi_idx : lo_idx;
        rr_ptr_d      = (grant_idx_q == 3'(NUM_BTNS - 1)) ? 3'd0 : grant_idx_q + 3'd1;
    end

`ifdef DEBOUNCE_RESTART_EN
    // Synchronised level of whichever button owns the timer.
    logic granted_level;

    always_comb begin
        granted_level = 1'b1;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (grant_idx_q == 3'(i)) granted_level = sync2_q[i];
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Shared timer FSM. Arbitration happens only in T_IDLE, so a button that
    // reaches PEND mid-window waits for the next idle cycle. The pulse is
    // registered on the way into T_DONE, giving exactly one cycle of pulse
    // while the timer sits in T_DONE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_state_q   <= T_IDLE;
            count_q       <= '0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            busy_q        <= 1'b0;
            press_pulse_q <= '0;
        end else begin
            press_pulse_q <= '0;
            case (tmr_state_q)
                T_IDLE: begin
                    if (grant_valid_d) begin
                        grant_idx_q <= grant_idx_d;
                        count_q     <= '0;
                        busy_q      <= 1'b1;
                        tmr_state_q <= T_RUN;
                    end
                end
                T_RUN: begin
`ifdef DEBOUNCE_RESTART_EN
                    // A bounce on the owner restarts the window in place;
                    // grant and state are kept.
                    if (!granted_level) begin
                        count_q <= '0;
                    end else
`endif
                    if (count_q == LAST_COUNT) begin
                        press_pulse_q <= pulse_d;
                        tmr_state_q   <= T_DONE;
                    end else begin
                        count_q <= count_q + 22'd1;
                    end
                end
                T_DONE: begin
                    rr_ptr_q    <= rr_ptr_d;
                    busy_q      <= 1'b0;
                    tmr_state_q <= T_IDLE;
                end
                default: begin
                    busy_q      <= 1'b0;
                    tmr_state_q <= T_IDLE;
                end
            endcase
        end
    end

    assign bus.press_pulse = press_pulse_q;
    assign bus.busy        = busy_q;
    assign bus.grant_idx   = grant_idx_q;
    assign bus.pend_mask   = pend;

endmodule

// File: tb/tb_debounce_scheduler.sv
// ---------------------------------------------------------------------------
// tb_debounce_scheduler
//
// Self-checking bench for debounce_scheduler (NUM_BTNS=4, DEBOUNCE_CYCLES=8).
// A timestamp-based reference model predicts every output each cycle:
// a window is described by its owner and the cycle its count was zero,
// and the pulse is due DEBOUNCE_CYCLES cycles later. Directed scenarios
// add timing and ordering checks on top of the per-cycle comparison, then
// a randomized toggle phase exercises arbitration under load.
// ---------------------------------------------------------------------------
module tb_debounce_scheduler;

    localparam int N = 4;
    localparam int D = 8;

    localparam int P_UP   = 0;   // released, idle
    localparam int P_DOWN = 1;   // held down
    localparam int P_WAIT = 2;   // released, waiting for / owning the timer

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    debounce_scheduler_if #(.NUM_BTNS(N)) bus ();

    debounce_scheduler #(
        .NUM_BTNS        (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    bit [N-1:0] m_s1;
    bit [N-1:0] m_s;
    int         m_phase [N];
    bit         m_busy;
    int         m_owner;
    int         m_rr;
    int         m_win_start;

    // Observed pulses
    int q_pidx [$];
    int q_pcyc [$];
    int q_pgnt [$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic void model_reset();
        m_s1        = '1;
        m_s         = '1;
        for (int i = 0; i < N; i++) m_phase[i] = P_UP;
        m_busy      = 1'b0;
        m_owner     = 0;
        m_rr        = 0;
        m_win_start = 0;
    endfunction

    // Advance the model across one clock edge; cyc already names the new cycle.
    function automatic void model_step(input bit [N-1:0] btn);
        int  ph [N];
        bit  finished;
        finished = m_busy && (cyc - 1 == m_win_start + D);
        for (int i = 0; i < N; i++) begin
            ph[i] = m_phase[i];
            if (m_phase[i] == P_UP && !m_s[i]) ph[i] = P_DOWN;
            if (m_phase[i] == P_DOWN && m_s[i]) ph[i] = P_WAIT;
            if (m_phase[i] == P_WAIT && finished && m_owner == i) ph[i] = P_UP;
        end
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_rr + k) % N;
                if (!m_busy && m_phase[j] == P_WAIT) begin
                    m_busy      = 1'b1;
                    m_owner     = j;
                    m_win_start = cyc;
                end
            end
        end else if (finished) begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % N;
        end else begin
`ifdef DEBOUNCE_RESTART_EN
            if (!m_s[m_owner]) m_win_start = cyc;
`endif
        end
        for (int i = 0; i < N; i++) m_phase[i] = ph[i];
        m_s  = m_s1;
        m_s1 = btn;
    endfunction

    function automatic logic [31:0] exp_pulse();
        if (m_busy && cyc == m_win_start + D) return 32'd1 << m_owner;
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_pend();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < N; i++) if (m_phase[i] == P_WAIT) m[i] = 1'b1;
        return m;
    endfunction

    // One clock: model update at the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_step(bus.btn_n);
        @(negedge clk);
        check("press_pulse", 32'(bus.press_pulse), exp_pulse());
        check("busy",        32'(bus.busy),        32'(m_busy));
        check("grant_idx",   32'(bus.grant_idx),   32'(m_owner));
        check("pend_mask",   32'(bus.pend_mask),   exp_pend());
        for (int i = 0; i < N; i++) begin
            if (bus.press_pulse[i] === 1'b1) begin
                q_pidx.push_back(i);
                q_pcyc.push_back(cyc);
                q_pgnt.push_back(int'(bus.grant_idx));
            end
        end
    endtask

    task automatic clear_pulses();
        q_pidx.delete();
        q_pcyc.delete();
        q_pgnt.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pulse"}, 32'(bus.press_pulse), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),        32'd0);
        check({tag, "_grant"}, 32'(bus.grant_idx),   32'd0);
        check({tag, "_pend"},  32'(bus.pend_mask),   32'd0);
    endtask

    task automatic do_reset();
        bus.btn_n = '1;
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic run_until_pulses(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && q_pidx.size() < n; k++) tick();
        check({tag, "_npulses"}, 32'(q_pidx.size()), 32'(n));
    endtask

    task automatic wait_window(input int idx, input string tag, output int w);
        bit found;
        found = 1'b0;
        w = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (bus.busy === 1'b1 && bus.grant_idx === 3'(idx)) begin
                found = 1'b1;
                w = cyc;
            end
        end
        check({tag, "_window_start"}, 32'(found), 32'd1);
    endtask

    task automatic single_press(input string tag, input int idx);
        int p;
        bit seen;
        clear_pulses();
        bus.btn_n[idx] = 1'b0;
        repeat (5) tick();
        bus.btn_n[idx] = 1'b1;
        seen = 1'b0;
        p = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus.pend_mask[idx] === 1'b1) begin
                seen = 1'b1;
                p = cyc;
            end
        end
        check({tag, "_pend_seen"}, 32'(seen), 32'd1);
        run_until_pulses(1, 40, tag);
        if (q_pidx.size() > 0) begin
            check({tag, "_idx"},     32'(q_pidx[0]),     32'(idx));
            check({tag, "_grant"},   32'(q_pgnt[0]),     32'(idx));
            check({tag, "_latency"}, 32'(q_pcyc[0] - p), 32'(D + 1));
        end
        repeat (15) tick();
        check({tag, "_exactly_one"}, 32'(q_pidx.size()), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int busy_seen;

        // Reset state, checked while reset is still asserted
        rst = 1'b1;
        bus.btn_n = '1;
        model_reset();
        #1;
        check_outputs_zero("reset");
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Single press on button 1
        single_press("single", 1);

        // Simultaneous releases of buttons 0, 2, 3 with rr_ptr back at 0
        do_reset();
        clear_pulses();
        bus.btn_n = 4'b0010;
        repeat (4) tick();
        bus.btn_n = '1;
        run_until_pulses(3, 100, "simul");
        if (q_pidx.size() >= 3) begin
            check("simul_first",  32'(q_pidx[0]), 32'd0);
            check("simul_second", 32'(q_pidx[1]), 32'd2);
            check("simul_third",  32'(q_pidx[2]), 32'd3);
            check("simul_gap01",  32'(q_pcyc[1] - q_pcyc[0]), 32'(D + 2));
            check("simul_gap12",  32'(q_pcyc[2] - q_pcyc[1]), 32'(D + 2));
        end

        // Round-robin fairness: button 0 keeps bouncing while 3 waits
        do_reset();
        clear_pulses();
        bus.btn_n[0] = 1'b0;
        repeat (3) tick();
        bus.btn_n[0] = 1'b1;
        repeat (2) tick();
        bus.btn_n[3] = 1'b0;
        repeat (3) tick();
        bus.btn_n[3] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bus.btn_n[0] = ~bus.btn_n[0];
            tick();
        end
        bus.btn_n[0] = 1'b1;
        repeat (30) tick();
        check("fair_enough_pulses", 32'(q_pidx.size() >= 3), 32'd1);
        if (q_pidx.size() >= 3) begin
            check("fair_first",  32'(q_pidx[0]), 32'd0);
            check("fair_second", 32'(q_pidx[1]), 32'd3);
            check("fair_third",  32'(q_pidx[2]), 32'd0);
            check("fair_gap",    32'(q_pcyc[1] - q_pcyc[0]), 32'(D + 2));
        end

        // Bounce on granted button 2 at count 5
        do_reset();
        clear_pulses();
        bus.btn_n[2] = 1'b0;
        repeat (3) tick();
        bus.btn_n[2] = 1'b1;
        wait_window(2, "bounce", w);
        repeat (3) tick();
        bus.btn_n[2] = 1'b0;          // synchronised low lands at count 5
        tick();
        bus.btn_n[2] = 1'b1;
        run_until_pulses(1, 40, "bounce");
        if (q_pidx.size() > 0) begin
            check("bounce_idx", 32'(q_pidx[0]), 32'd2);
`ifdef DEBOUNCE_RESTART_EN
            check("bounce_cycle", 32'(q_pcyc[0] - w), 32'(6 + D));
`else
            check("bounce_cycle", 32'(q_pcyc[0] - w), 32'(D));
`endif
        end
        repeat (10) tick();

        // Reset asserted mid-window at count 4
        do_reset();
        clear_pulses();
        bus.btn_n[1] = 1'b0;
        repeat (3) tick();
        bus.btn_n[1] = 1'b1;
        wait_window(1, "midrst", w);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs_zero("midrst");
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("midrst_no_pulse", 32'(q_pidx.size()), 32'd0);
        single_press("after_rst", 1);

        // Hold without release
        clear_pulses();
        busy_seen = 0;
        bus.btn_n[0] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.busy !== 1'b0) busy_seen++;
        end
        check("hold_busy_cycles", 32'(busy_seen), 32'd0);
        check("hold_no_pulse", 32'(q_pidx.size()), 32'd0);
        bus.btn_n[0] = 1'b1;
        run_until_pulses(1, 30, "hold_release");
        repeat (10) tick();
        check("hold_exactly_one", 32'(q_pidx.size()), 32'd1);
        if (q_pidx.size() > 0) check("hold_idx", 32'(q_pidx[0]), 32'd0);

        // Randomized toggling under load, checked cycle by cycle by the model
        clear_pulses();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(11) == 0) bus.btn_n[i] = ~bus.btn_n[i];
            end
            tick();
        end
        bus.btn_n = '1;
        repeat (80) tick();
        check("random_drained_busy", 32'(bus.busy), 32'd0);
        check("random_drained_pend", 32'(bus.pend_mask), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Shares one debounce timer among up to eight active-low push buttons. Each button is synchronised and tracked through press and release. Released buttons queue for the timer, and a round-robin arbiter grants it to one button at a time. After the timer window expires, the block emits a one-cycle press pulse per button. It sits between the raw board buttons and the count/display logic, replacing one wide counter per button.

## Interface
- NUM_BTNS, 4: number of buttons; legal range 1..8.
- DEBOUNCE_CYCLES, 2400000: length of the debounce window in clk cycles (200 ms at 12 MHz); minimum 2, fits in 22 bits.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_n  in  NUM_BTNS  raw buttons, active-low, asynchronous to clk.
- press_pulse  out  NUM_BTNS  one-cycle pulse per debounced press; reset value 0.
- busy  out  1  high while the timer is not in T_IDLE; reset value 0.
- grant_idx  out  3  index of the button owning the timer; holds its last value when idle; reset value 0.
- pend_mask  out  NUM_BTNS  bit i high while button i is in PEND; reset value 0.

## Operation
- **Synchroniser.** Each btn_n bit passes through two flops. Both flops reset to 1 (released). All logic below uses the synchronised level s[i].
- **Per-button FSM** (reset HIGH):
  - HIGH: s[i]=0 → LOW.
  - LOW: s[i]=1 → PEND.
  - PEND: hold until granted and finished. s[i] is ignored unless the button is granted.
- **Timer FSM** (reset T_IDLE, count 0):
  - T_IDLE: if any button is in PEND, grant the first PEND index at or after rr_ptr (wrapping modulo NUM_BTNS). Load grant_idx, clear count, go to T_RUN.
  - T_RUN: count+1 each cycle. When count==DEBOUNCE_CYCLES-1, go to T_DONE.
  - T_DONE: press_pulse[grant_idx]=1 for this cycle only. On the next edge:
    - the granted button goes PEND→HIGH;
    - rr_ptr becomes (grant_idx+1) mod NUM_BTNS;
    - the timer goes to T_IDLE.
- rr_ptr resets to 0. Arbitration happens only in T_IDLE; a PEND that arrives mid-window waits.
- Count width is 22 bits and never wraps, because the compare terminates the window.
- At most one press_pulse bit is high in any cycle.
- press_pulse is registered, with no combinational path from btn_n.

## Timing
- btn_n edge to s[i] change: 2 cycles.
- s[i] rising while in LOW at cycle c → PEND visible (pend_mask) at c+1.
- PEND with timer idle at cycle p:
  - RUN with count 0 at p+1;
  - T_DONE and pulse at p+DEBOUNCE_CYCLES+1;
  - button back in HIGH at p+DEBOUNCE_CYCLES+2.
- Back-to-back grants: T_DONE → T_IDLE → next grant gives 2 dead cycles between windows.
- Simultaneous PEND entries: the lowest index at or after rr_ptr wins; the others are served in round-robin order.
- A button entering PEND in the same cycle the timer is in T_IDLE is eligible that cycle (pend_mask registered before arbitration, so effectively eligible the next cycle).
- Reset asserted mid-window: all FSMs, count, rr_ptr and outputs clear immediately. No pulse is emitted for the interrupted window.
- Deasserting rst: the synchroniser holds 1 for 2 cycles, so no spurious LOW is seen.

## Configuration
- DEBOUNCE_RESTART_EN:
  - Defined: in T_RUN, if s[grant_idx]==0, count clears to 0 and the window restarts. The grant and state are kept, so the pulse only follows DEBOUNCE_CYCLES consecutive high samples.
  - Undefined: the granted button's input is ignored during T_RUN (fixed window from the first release).

## Test plan
- **Single press** (NUM_BTNS=4, DEBOUNCE_CYCLES=8, rst released):
  - Stimulus: btn_n[1] low for 5 cycles, then high.
  - Required: exactly one pulse on press_pulse[1]; grant_idx=1; pulse 8+1 cycles after pend_mask[1] rises.
- **Simultaneous releases:** buttons 0, 2 and 3 released in the same cycle with rr_ptr=0.
  - Required: pulses in order 0, 2, 3, windows separated by 2 dead cycles, busy high throughout each window.
- **Round-robin fairness:** button 0 is repeatedly pressed and released while button 3 is pending.
  - Required: button 3 is granted right after button 0's window; button 0 is never granted twice in a row while button 3 is pending.
- **Bounce during window** (button 2 granted; glitch low for 1 cycle at count=5):
  - With DEBOUNCE_RESTART_EN: pulse is delayed, arriving 8 cycles after the glitch clears.
  - Without it: pulse arrives at the nominal cycle.
- **Reset mid-window:** rst asserted at count=4 for 1 cycle.
  - Required: all outputs read 0 immediately, no press_pulse for the aborted button, and a subsequent press behaves as the single-press case.
- **Hold without release:** btn_n[0] held low for 100 cycles.
  - Required: no pulse and busy stays 0. On release, exactly one pulse follows.
